bcd_to_bin_seq: RTL and testbench

BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

---
 rtl/bcd_to_bin_seq_pkg.sv | 18 +
 rtl/bcd_digit_corr.sv | 12 +
 rtl/bcd_to_bin_seq.sv | 115 +++++++++++
 tb/tb_bcd_to_bin_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
// Holds the FSM state type, default sizes and reverse double-dabble correction constants.
package bcd_to_bin_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_DIGITS = 4;
    localparam int DEF_BIN_W  = 14;

    // Digits at or above the threshold get the offset removed after each right shift.
    localparam logic [3:0] CORR_THRESH = 4'd8;
    localparam logic [3:0] CORR_OFFSET = 4'd3;

endpackage

// File: rtl/bcd_digit_corr.sv
// Per-digit correction for reverse double-dabble: a digit >= 8 has 3 subtracted.
// Purely combinational; one instance per BCD digit.
module bcd_digit_corr
    import bcd_to_bin_seq_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= CORR_THRESH) ? (din - CORR_OFFSET) : din;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter using reverse double-dabble.
// One bit of the result is produced per SHIFT cycle; BIN_W cycles per conversion.
module bcd_to_bin_seq
    import bcd_to_bin_seq_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS,
    parameter int BIN_W  = DEF_BIN_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             state;
    state_t             state_nx;
    logic [BCD_W-1:0]   work;
    logic [BCD_W-1:0]   work_sh;
    logic [BCD_W-1:0]   work_corr;
    logic [BIN_W-1:0]   sreg;
    logic [BIN_W-1:0]   sreg_sh;
    logic [CNT_W-1:0]   cnt;
    logic               err_pend;
    logic               bad_in;
    logic               last_iter;

    function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    assign bad_in    = has_bad_digit(bcd_in);
    assign last_iter = (cnt == CNT_W'(BIN_W - 1));

    // The working LSB drops into the MSB of the result register each cycle.
    assign work_sh = work >> 1;
    assign sreg_sh = {work[0], sreg[BIN_W-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_corr
        bcd_digit_corr u_corr (
            .din  (work_sh[4*g +: 4]),
            .dout (work_corr[4*g +: 4])
        );
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (err_pend)                state_nx = DONE;
                else if (start && !bad_in)   state_nx = SHIFT;
            end
            SHIFT: begin
                if (last_iter)               state_nx = DONE;
            end
            DONE:                            state_nx = IDLE;
            default:                         state_nx = IDLE;
        endcase
    end

    // An invalid request is captured, flagged for one cycle, then reported from DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            work     <= '0;
            sreg     <= '0;
            cnt      <= '0;
            err_pend <= 1'b0;
            bin_out  <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (err_pend) begin
                        err_pend <= 1'b0;
                        err      <= 1'b1;
                        bin_out  <= '0;
                    end else if (start) begin
                        work     <= bcd_in;
                        sreg     <= '0;
                        cnt      <= '0;
                        err_pend <= bad_in;
                    end
                end
                SHIFT: begin
                    work <= work_corr;
                    sreg <= sreg_sh;
                    if (!last_iter) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        bin_out <= sreg_sh;
                        err     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: expected results queued at request, compared on done.
module tb_bcd_to_bin_seq;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    logic               clk;
    logic               rst;
    logic               start;
    logic [15:0]        bcd_in;
    logic [BIN_W-1:0]   bin_out;
    logic               busy;
    logic               done;
    logic               err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [BIN_W:0] exp_q[$];

    bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .bin_out (bin_out),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check_eq("done_unexpected", 32'(done), 32'd0);
            end else begin
                logic [BIN_W:0] e;
                e = exp_q.pop_front();
                check_eq("bin_out", 32'(bin_out), 32'(e[BIN_W-1:0]));
                check_eq("err", 32'(err), 32'(e[BIN_W]));
            end
        end
    end

    // Caller is positioned 1 time unit after a rising edge with the DUT idle.
    task automatic run_conv(input logic [15:0] bcd, input int exp_bin, input bit exp_err);
        int lat;
        int busy_low;
        bcd_in = bcd;
        start  = 1'b1;
        exp_q.push_back({exp_err, BIN_W'(exp_bin)});
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        busy_low = 0;
        while (!done && lat < 40) begin
            if (!exp_err && !busy) busy_low++;
            @(posedge clk); #1;
            lat++;
        end
        check_eq("latency", 32'(lat), exp_err ? 32'd1 : 32'd14);
        if (!exp_err) check_eq("busy_run", 32'(busy_low), 32'd0);
        check_eq("busy_done", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check_eq("done_pulse", 32'(done), 32'd0);
        check_eq("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        int v;
        rst    = 1'b1;
        start  = 1'b0;
        bcd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_bin", 32'(bin_out), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        rst = 1'b0;

        // Start on the very first edge after reset release.
        run_conv(16'h0000, 0, 1'b0);
        run_conv(16'h1234, 1234, 1'b0);
        run_conv(16'h9999, 9999, 1'b0);
        run_conv(16'h12A4, 0, 1'b1);
        run_conv(16'hF000, 0, 1'b1);
        run_conv(16'h0001, 1, 1'b0);
        run_conv(16'h000A, 0, 1'b1);
        run_conv(16'h0800, 800, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check_eq("hold_bin", 32'(bin_out), 32'd800);
        check_eq("hold_err", 32'(err), 32'd0);

        // Second start mid-conversion must be dropped without queuing.
        bcd_in = 16'h0042;
        start  = 1'b1;
        exp_q.push_back({1'b0, BIN_W'(42)});
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bcd_in = 16'h0777;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 5;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("ignore_latency", 32'(lat), 32'd14);
        @(posedge clk); #1;
        repeat (20) @(posedge clk);
        #1;
        check_eq("ignore_noqueue", 32'(bin_out), 32'd42);
        run_conv(16'h0777, 777, 1'b0);

        // Reset part-way through a conversion aborts it.
        bcd_in = 16'h1234;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("abort_bin", 32'(bin_out), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_err", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_eq("abort_no_done", 32'(busy), 32'd0);
        run_conv(16'h0567, 567, 1'b0);

        // Round trip over the low and high ends plus a random sample.
        for (int i = 0; i < 40; i++) run_conv(to_bcd(i), i, 1'b0);
        for (int i = 9960; i < 10000; i++) run_conv(to_bcd(i), i, 1'b0);
        for (int i = 0; i < 150; i++) begin
            v = int'($urandom_range(9999, 0));
            run_conv(to_bcd(v), v, 1'b0);
        end

        repeat (4) @(posedge clk);
        #1;
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
